// File: rtl/matrix_column_scanner_if.sv
// matrix_column_scanner_if
//   Groups the scanner's pattern inputs and matrix drive outputs.
//   master : the side that supplies patterns and enable (image mux / bench)
//   slave  : the scanner itself
//   Signals:
//     enable      scan enable, low forces the matrix dark
//     col_0..2    7-bit column patterns, bit r = row r lit
//     column_n    one-hot active-low column enable
//     row_n       active-low row drive for the selected column
//     frame_start one-cycle pulse in the snapshot (LOAD) cycle
interface matrix_column_scanner_if;
  logic       enable;
  logic [6:0] col_0;
  logic [6:0] col_1;
  logic [6:0] col_2;
  logic [2:0] column_n;
  logic [6:0] row_n;
  logic       frame_start;

  modport master (
    output enable, col_0, col_1, col_2,
    input  column_n, row_n, frame_start
  );

  modport slave (
    input  enable, col_0, col_1, col_2,
    output column_n, row_n, frame_start
  );
endinterface

// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner
//   Strobes a 3-column x 7-row LED matrix from three column patterns.
//   All three patterns are snapshotted once per frame (LOAD), then each
//   column is driven for PRESCALE cycles followed by BLANK_CYCLES of dark
//   time to suppress ghosting. Scan order is always column 0, 1, 2.
//   Frame period = 1 + 3*(PRESCALE + BLANK_CYCLES) cycles.
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset, forces all drive off
//     mx       slave side of matrix_column_scanner_if (patterns in,
//              column_n/row_n/frame_start out, all outputs registered)
module matrix_column_scanner #(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                     clock,
  input  logic                     reset_n,
  matrix_column_scanner_if.slave   mx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRIVE,
    BLANK
  } state_t;

  localparam logic [15:0] DRIVE_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  state_t          state;
  logic [2:0][6:0] frame_buf;
  logic [1:0]      col_idx;
  logic [15:0]     cnt;
  logic [2:0]      column_q;
  logic [6:0]      row_q;
  logic            frame_start_q;

  // One-hot active-low column select for a column index.
  function automatic logic [2:0] column_sel_n(input logic [1:0] idx);
    column_sel_n = ~(3'b001 << idx);
  endfunction

  assign mx.column_n    = column_q;
  assign mx.row_n       = row_q;
  assign mx.frame_start = frame_start_q;

  // Outputs are computed from the state being entered, so they are valid
  // for the whole time the FSM sits in that state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      frame_buf     <= '0;
      col_idx       <= 2'd0;
      cnt           <= 16'd0;
      column_q      <= 3'b111;
      row_q         <= 7'h7F;
      frame_start_q <= 1'b0;
    end else begin
      // Dark by default; only entry into DRIVE turns a column on.
      column_q      <= 3'b111;
      row_q         <= 7'h7F;
      frame_start_q <= 1'b0;

      if (state != IDLE && !mx.enable) begin
        // Abort the frame; the snapshot is kept but never reused because
        // re-enabling always passes through LOAD first.
        state   <= IDLE;
        cnt     <= 16'd0;
        col_idx <= 2'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (mx.enable) begin
              state         <= LOAD;
              frame_start_q <= 1'b1;
            end
          end

          LOAD: begin
            frame_buf <= {mx.col_2, mx.col_1, mx.col_0};
            col_idx   <= 2'd0;
            cnt       <= 16'd0;
            state     <= DRIVE;
            // Buffer is not written yet, so column 0 comes straight from
            // the value being captured.
            column_q  <= column_sel_n(2'd0);
            row_q     <= ~mx.col_0;
          end

          DRIVE: begin
            if (cnt == DRIVE_LAST) begin
              cnt   <= 16'd0;
              state <= BLANK;
            end else begin
              cnt      <= cnt + 16'd1;
              column_q <= column_sel_n(col_idx);
              row_q    <= ~frame_buf[col_idx];
            end
          end

          BLANK: begin
            if (cnt == BLANK_LAST) begin
              cnt <= 16'd0;
              if (col_idx == 2'd2) begin
                state         <= LOAD;
                frame_start_q <= 1'b1;
              end else begin
                col_idx  <= col_idx + 2'd1;
                state    <= DRIVE;
                column_q <= column_sel_n(col_idx + 2'd1);
                row_q    <= ~frame_buf[col_idx + 2'd1];
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner
//   Bench for matrix_column_scanner with PRESCALE=4, BLANK_CYCLES=2
//   (19-cycle frame). A frame-position model predicts the registered
//   outputs after every rising edge and queues them; the falling-edge
//   monitor pops and compares, and also checks the drive invariants.
module tb_matrix_column_scanner;

  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = P + B;
  localparam int FRAME = 1 + 3 * SLOT;

  logic clock;
  logic reset_n;

  matrix_column_scanner_if mx ();

  matrix_column_scanner #(
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mx      (mx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: inactive = IDLE; active with position 0 = LOAD, positions
  // 1..18 walk the three column slots (4 drive + 2 blank each).
  bit         m_active;
  int         m_pos;
  logic [6:0] m_buf [3];

  logic [10:0] exp_q [$];

  function automatic logic [10:0] model_out();
    int q, c, r;
    if (!m_active) return {3'b111, 7'h7F, 1'b0};
    if (m_pos == 0) return {3'b111, 7'h7F, 1'b1};
    q = m_pos - 1;
    c = q / SLOT;
    r = q % SLOT;
    if (r < P) return {~(3'b001 << c), ~m_buf[c], 1'b0};
    return {3'b111, 7'h7F, 1'b0};
  endfunction

  // Advance one clock; inputs are only changed 1 time unit after the edge,
  // so the values read here are the ones the DUT sampled.
  task automatic step();
    @(posedge clock);
    if (!reset_n) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_buf    = '{default: 7'h00};
    end else if (!m_active) begin
      if (mx.enable) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (!mx.enable) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      if (m_pos == 0) begin
        m_buf[0] = mx.col_0;
        m_buf[1] = mx.col_1;
        m_buf[2] = mx.col_2;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int pos);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_active && m_pos == pos) break;
      step();
    end
    check("reach_pos", m_pos, pos);
  endtask

  always @(negedge clock) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("column_n",    mx.column_n,    e[10:8]);
      check("row_n",       mx.row_n,       e[7:1]);
      check("frame_start", mx.frame_start, e[0]);
    end
    check("one_column", ($countones(~mx.column_n) <= 1), 1);
    check("dark_rows", (mx.column_n != 3'b111) || (mx.row_n == 7'h7F), 1);
  end

  initial begin
    m_active  = 1'b0;
    m_pos     = 0;
    m_buf     = '{default: 7'h00};
    reset_n   = 1'b0;
    mx.enable = 1'b1;
    mx.col_0  = 7'h55;
    mx.col_1  = 7'h2A;
    mx.col_2  = 7'h7F;

    // Reset held with enable high, then two full frames.
    run(3);
    reset_n = 1'b1;
    run(2 * FRAME + 1);

    // Pattern change during column 0 must not reach column 1 this frame.
    run_until(2);
    mx.col_1 = 7'h00;
    run(2 * FRAME);

    // Enable dropped for 3 cycles during column-1 drive.
    mx.col_1 = 7'h2A;
    run_until(8);
    mx.enable = 1'b0;
    run(3);
    mx.enable = 1'b1;
    run(FRAME + 6);

    // Asynchronous reset in the middle of column-2 drive.
    run_until(14);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_column_n", mx.column_n, 3'b111);
    check("async_row_n",    mx.row_n,    7'h7F);
    check("async_fs",       mx.frame_start, 1'b0);
    run(2);
    reset_n = 1'b1;
    run(3 * FRAME + 2);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_column_scanner.md
Name: matrix_column_scanner

Overview:
- Drives the LED matrix from the three 7-bit column patterns (col_2/col_1/col_0) produced by the display-mode selector.
- Snapshots all three columns at each frame start, then strobes one column at a time with active-low column and row drive.
- Inserts a blanking gap between columns to suppress ghosting.
- Sits between the image mux and the board matrix pins.

Parameters:
- PRESCALE, 50000, clock cycles each column is driven; valid range 1..65535.
- BLANK_CYCLES, 500, clock cycles all drive is off between columns; valid range 1..65535.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; low forces the matrix dark.
- col_0  input  7  pattern for matrix column 0; bit r = row r lit (1 = on).
- col_1  input  7  pattern for matrix column 1.
- col_2  input  7  pattern for matrix column 2.
- column_n  output  3  one-hot active-low column enable; bit i selects column i.
- row_n  output  7  active-low row drive for the selected column.
- frame_start  output  1  one-cycle pulse in the cycle the snapshot is taken.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: column_n=3'b111, row_n=7'h7F, frame_start=0.
  - Internal: state=IDLE, frame buffer=0, column index=0, 16-bit cycle counter=0.
- Outputs are registered and reflect the current state; there is no combinational path from inputs to outputs.
- IDLE:
  - All outputs off.
  - If enable=1, go to LOAD next edge; otherwise stay.
- LOAD (1 cycle):
  - Buffer captures col_0..col_2 at the edge leaving LOAD.
  - frame_start=1, all drive off.
  - Index=0, counter=0; go to DRIVE.
- DRIVE (exactly PRESCALE cycles):
  - column_n bit[index]=0, all other bits 1; row_n = ~buffer[index].
  - Counter increments each cycle; at count PRESCALE-1, clear counter and go to BLANK.
- BLANK (exactly BLANK_CYCLES cycles):
  - column_n=111, row_n=7F.
  - At count BLANK_CYCLES-1, clear counter, then:
    - if index<2: index+1, go to DRIVE;
    - if index==2: go to LOAD.
- Scan order is always col_0, col_1, col_2. Frame period = 1 + 3*(PRESCALE+BLANK_CYCLES) cycles.
- Input changes during a frame are ignored until the next LOAD (no tearing).
- enable=0 in any non-IDLE state:
  - Next edge goes to IDLE, outputs off, counter and index cleared; buffer is kept.
  - Re-enabling always starts a fresh frame via LOAD at column 0.
- An all-zero column is still selected for its full slot with row_n=7F; timing is unchanged.
- Async reset mid-frame forces all outputs off immediately, without waiting for a clock edge.
- Never more than one column_n bit low; never a row low while column_n=111.

Test Plan:
- Use PRESCALE=4, BLANK_CYCLES=2 (frame = 19 cycles) for all scenarios.
- Reset with enable=1 held → column_n=111, row_n=7F, frame_start=0 during reset. After release: 1 IDLE cycle, then the LOAD cycle with frame_start=1, then column_n=110.
- col_0=7'h55, col_1=7'h2A, col_2=7'h7F, enable=1 → expected sequence:
  - column_n=110 / row_n=2A for 4 cycles; then 111/7F for 2 cycles;
  - 101/55 for 4 cycles; then 111/7F for 2 cycles;
  - 011/00 for 4 cycles; then 111/7F for 2 cycles;
  - frame_start pulses every 19 cycles.
- Set col_1=0 while column 0 is driven → column 1 still shows row_n=55 this frame. The next frame shows row_n=7F with column_n=101 for 4 cycles.
- Drop enable for 3 cycles during the column-1 DRIVE → next cycle column_n=111, row_n=7F. After re-enable: LOAD with frame_start=1, then column_n=110 (restarts at col_0).
- Assert reset_n=0 asynchronously mid-DRIVE of column 2 → column_n=111 and row_n=7F before the next clock edge; scan restarts as in the reset scenario.
- Scan an assertion checker over 3 full frames → at most one column_n bit low, and no row_n bit low while column_n=111.
